ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit upstream of the decode/execute stage.
- Holds the fetch PC and issues one instruction-memory request at a time over a valid/ready request channel, then accepts the response.
- Presents {pc, inst} to decode over a valid/ready handshake.
- Accepts a redirect (jump/branch target) from execute, and discards any in-flight fetch that the redirect makes stale.

Parameters:
- RESET_PC, 32'h8000_0000, fetch PC loaded on reset.
- XLEN, 32, width of PC, address and instruction words.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  output  1  instruction-memory request valid.
- req_ready  input  1  memory accepts the request this cycle.
- req_addr  output  XLEN  request address (the current fetch PC).
- rsp_valid  input  1  memory response valid; single-cycle pulse.
- rsp_data  input  XLEN  fetched instruction word.
- out_valid  output  1  {out_pc, out_inst} valid to decode.
- out_ready  input  1  decode consumes the output this cycle.
- out_pc  output  XLEN  PC of the presented instruction.
- out_inst  output  XLEN  presented instruction.
- out_fault  output  1  instruction-fetch fault flag; tied 0 unless the optional feature is compiled in.
- redirect_valid  input  1  load redirect_pc as the next fetch PC.
- redirect_pc  input  XLEN  redirect target.

Behaviour:
- Reset (async, any state): state=REQ, pc=RESET_PC, drop=0, out_valid=0, out_pc=0, out_inst=0, out_fault=0. req_valid is combinational and equals 1 in REQ, so it is high from the first cycle after rst deasserts.
- State REQ:
  - req_valid=1, req_addr=pc.
  - req_valid/req_addr stay stable until req_ready, unless a redirect arrives.
  - On req_ready: go to WAIT.
- State WAIT:
  - req_valid=0.
  - On rsp_valid with drop=0: latch out_inst=rsp_data, out_pc=pc, set out_valid=1, go to OUT.
  - On rsp_valid with drop=1: discard the response, clear drop, go to REQ.
- State OUT:
  - out_valid=1; out_* stay stable until out_ready.
  - On out_ready: out_valid<=0, pc<=pc+4 (modulo 2^XLEN, wraps 0xFFFF_FFFC to 0), go to REQ.
- Only one outstanding request at any time.
- Memory must not assert rsp_valid in the same cycle the request is accepted; rsp_valid outside WAIT is ignored.
- Minimum latency from acceptance: response the cycle after acceptance gives out_valid the following cycle.
- Redirect (takes priority over the normal PC update):
  - In REQ without req_ready: pc<=redirect_pc, stay in REQ. The new address appears next cycle.
  - In REQ with req_ready in the same cycle: the old request is already issued. pc<=redirect_pc, drop<=1, go to WAIT.
  - In WAIT with no rsp_valid: pc<=redirect_pc, drop<=1.
  - In WAIT with rsp_valid in the same cycle: discard the response, pc<=redirect_pc, drop<=0, go to REQ.
  - In OUT: kill the output (out_valid<=0, even if out_ready is high), pc<=redirect_pc, go to REQ.
- Back-to-back redirects: the last one wins; drop never counts above 1.
- Throughput: one instruction per 3 cycles minimum (REQ, WAIT, OUT).

Optional Feature:
- Macro IFU_MISALIGN_CHECK_EN.
- Defined:
  - A PC with pc[1:0]!=0 on entering REQ issues no memory request.
  - Next cycle the block goes to OUT with out_fault=1, out_inst=32'h0000_0013 (nop) and out_pc=that pc.
  - out_fault clears when the output is consumed or killed.
  - Redirect rules are unchanged.
- Undefined: no check; out_fault is constant 0 and misaligned addresses are issued unchanged.

Test Plan:
- Reset then memory with req_ready=1 and 1-cycle response: req_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; out_pc and out_inst match the memory contents; one output every 3 cycles.
- Hold req_ready=0 for 5 cycles: req_valid=1 and req_addr=0x8000_0000 stable throughout. Hold out_ready=0 for 4 cycles: out_* stable and no new req_valid.
- Redirect to 0x8000_0100 during WAIT: the late response (0xDEAD_BEEF) never appears on out_*; the next req_addr is 0x8000_0100.
- Redirect to 0x8000_0200 in OUT with out_ready=1 in the same cycle: the instruction is not consumed; the next req_addr is 0x8000_0200.
- Assert rst in WAIT: out_valid=0 immediately; the response arriving after rst deasserts is ignored; the first req_addr is 0x8000_0000.
- With IFU_MISALIGN_CHECK_EN, redirect to 0x8000_0102: no req_valid is issued; out_fault=1, out_pc=0x8000_0102, out_inst=0x0000_0013.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem request, valid/ready output to decode, redirect with stale-response drop.
// Optional misaligned-PC fault generation is compiled in with `define IFU_MISALIGN_CHECK_EN.
module ifu_fetch #(
    parameter int unsigned XLEN               = 32,
    parameter logic [XLEN-1:0] RESET_PC       = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic            out_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_inst_q, out_inst_d;
`ifdef IFU_MISALIGN_CHECK_EN
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);
    logic            fault_q, fault_d;
    logic            misaligned;
    assign misaligned = (pc_q[1:0] != 2'b00);
    assign out_fault  = fault_q;
`else
    assign out_fault  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            drop_q     <= 1'b0;
            out_pc_q   <= '0;
            out_inst_q <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            drop_q     <= drop_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
`ifdef IFU_MISALIGN_CHECK_EN
            fault_q    <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
        req_valid  = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
        fault_d    = fault_q;
`endif
        case (state_q)
            S_REQ: begin
`ifdef IFU_MISALIGN_CHECK_EN
                req_valid = !misaligned;
`else
                req_valid = 1'b1;
`endif
                if (redirect_valid) begin
                    // An accepted request is already in flight; its response must be dropped.
                    pc_d = redirect_pc;
                    if (req_valid && req_ready) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
`ifdef IFU_MISALIGN_CHECK_EN
                end else if (misaligned) begin
                    state_d    = S_OUT;
                    out_pc_d   = pc_q;
                    out_inst_d = NOP;
                    fault_d    = 1'b1;
`endif
                end else if (req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    if (redirect_valid) begin
                        pc_d    = redirect_pc;
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        out_pc_d   = pc_q;
                        out_inst_d = rsp_data;
                        state_d    = S_OUT;
                    end
                end else if (redirect_valid) begin
                    pc_d   = redirect_pc;
                    drop_d = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
`ifdef IFU_MISALIGN_CHECK_EN
                    fault_d = 1'b0;
`endif
                end else if (out_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
`ifdef IFU_MISALIGN_CHECK_EN
                    fault_d = 1'b0;
`endif
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    assign req_addr  = pc_q;
    assign out_valid = (state_q == S_OUT);
    assign out_pc    = out_pc_q;
    assign out_inst  = out_inst_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed scenarios followed by a randomized run against a PC-stream reference model.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    ifu_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_fault(out_fault),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Starting at a negedge with the DUT in REQ: issue, respond next cycle, consume.
    task automatic fetch_one(input logic [31:0] a);
        chk("fo_req_valid", 32'(req_valid), 32'd1);
        chk("fo_req_addr", req_addr, a);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        chk("fo_wait_req_valid", 32'(req_valid), 32'd0);
        rsp_valid = 1'b1;
        rsp_data  = mem(a);
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("fo_out_valid", 32'(out_valid), 32'd1);
        chk("fo_out_pc", out_pc, a);
        chk("fo_out_inst", out_inst, mem(a));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [31:0] exp_pc;
    logic [31:0] paddr;
    logic        pending;
    logic        real_rsp;
    int          cnt;
    int          consumed;

    initial begin
        rst = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_valid", 32'(req_valid), 32'd1);
        chk("rst_req_addr", req_addr, 32'h8000_0000);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_fault", 32'(out_fault), 32'd0);

        // request stall
        repeat (5) begin
            @(negedge clk);
            chk("stall_req_valid", 32'(req_valid), 32'd1);
            chk("stall_req_addr", req_addr, 32'h8000_0000);
        end

        // back-to-back fetches, one output every 3 cycles
        fetch_one(32'h8000_0000);
        fetch_one(32'h8000_0004);
        fetch_one(32'h8000_0008);

        // output stall
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_data = mem(32'h8000_000C);
        @(negedge clk);
        rsp_valid = 1'b0;
        repeat (4) begin
            chk("ostall_valid", 32'(out_valid), 32'd1);
            chk("ostall_pc", out_pc, 32'h8000_000C);
            chk("ostall_inst", out_inst, mem(32'h8000_000C));
            chk("ostall_no_req", 32'(req_valid), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("ostall_next_addr", req_addr, 32'h8000_0010);

        // redirect during WAIT, late response dropped
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("rdw_still_wait", 32'(req_valid), 32'd0);
        rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("rdw_no_out", 32'(out_valid), 32'd0);
        chk("rdw_req_valid", 32'(req_valid), 32'd1);
        fetch_one(32'h8000_0100);

        // redirect in OUT with out_ready: not consumed
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_data = mem(32'h8000_0104);
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("rdo_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        @(negedge clk);
        out_ready = 1'b0; redirect_valid = 1'b0;
        chk("rdo_killed", 32'(out_valid), 32'd0);
        fetch_one(32'h8000_0200);

        // async reset in WAIT; post-reset response ignored
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rstw_out_valid", 32'(out_valid), 32'd0);
        chk("rstw_req_valid", 32'(req_valid), 32'd1);
        chk("rstw_req_addr", req_addr, 32'h8000_0000);
        @(negedge clk);
        rst = 1'b0;
        rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("rstw_ignored", 32'(out_valid), 32'd0);
        chk("rstw_addr", req_addr, 32'h8000_0000);

        // async reset in OUT
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_data = mem(32'h8000_0000);
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("rsto_pre", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rsto_out_valid", 32'(out_valid), 32'd0);
        chk("rsto_out_pc", out_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rsto_addr", req_addr, 32'h8000_0000);

`ifdef IFU_MISALIGN_CHECK_EN
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("mis_no_req", 32'(req_valid), 32'd0);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        chk("mis_out_valid", 32'(out_valid), 32'd1);
        chk("mis_fault", 32'(out_fault), 32'd1);
        chk("mis_pc", out_pc, 32'h8000_0102);
        chk("mis_inst", out_inst, 32'h0000_0013);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("mis_fault_clr", 32'(out_fault), 32'd0);
        chk("mis_again_no_req", 32'(req_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("mis_recover_addr", req_addr, 32'h8000_0300);
        chk("mis_recover_valid", 32'(req_valid), 32'd1);
`endif

        // redirect in REQ and PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        fetch_one(32'hFFFF_FFFC);
        chk("wrap_addr", req_addr, 32'h0000_0000);

        // randomized run: fetched stream must follow redirects and sequential +4 steps
        exp_pc = 32'h0000_0000;
        pending = 1'b0;
        cnt = 0;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            rsp_valid = 1'b0;
            rsp_data  = $urandom;
            real_rsp  = 1'b0;
            if (pending) begin
                if (cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_data  = mem(paddr);
                    pending   = 1'b0;
                    real_rsp  = 1'b1;
                end else begin
                    cnt--;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                rsp_valid = 1'b1;
            end
            req_ready      = 1'($urandom_range(0, 1));
            out_ready      = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom & 32'hFFFF_FFFC;

            if (out_valid) begin
                chk("rnd_out_pc", out_pc, exp_pc);
                chk("rnd_out_inst", out_inst, mem(exp_pc));
            end
            if (req_valid)
                chk("rnd_req_addr", req_addr, exp_pc);
            chk("rnd_one_outstanding", 32'(req_valid && (pending || real_rsp)), 32'd0);
            chk("rnd_excl_valid", 32'(req_valid && out_valid), 32'd0);
`ifndef IFU_MISALIGN_CHECK_EN
            chk("rnd_fault_zero", 32'(out_fault), 32'd0);
`endif
            if (req_valid && req_ready) begin
                pending = 1'b1;
                paddr   = req_addr;
                cnt     = $urandom_range(0, 2);
            end
            if (redirect_valid)
                exp_pc = redirect_pc;
            else if (out_valid && out_ready) begin
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            @(negedge clk);
        end
        req_ready = 1'b0; rsp_valid = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
        chk("rnd_progress", 32'(consumed >= 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
